cla_pipe_addsub: RTL
====================

// Module: cla_pipe_addsub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
//  Built from 4-bit lookahead groups, each with per-group g/p and c1..c3/co lookahead;
//  GPS groups are evaluated per pipeline stage, with group carries rippled inside a stage.
//  Adds operand streaming with valid/ready handshake, add/sub mode and NZCV-style flags.
// PARAMETERS
//  WIDTH  32  operand width; multiple of 4, >= 8
//  GPS    2   4-bit groups per pipeline stage; must divide WIDTH/4
//  (derived) NGRP = WIDTH/4, LAT = NGRP/GPS = pipeline depth in cycles (default 4)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      input operation valid
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op_sub     in   1      0: a+b+cin; 1: a+~b+1 (cin ignored)
//  cin        in   1      carry-in, add mode only
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  co         out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
//  neg        out  1      sum[WIDTH-1]
// BEHAVIOUR
//  - One clock, asynchronous active-high reset; all flops clear on reset assertion.
//  - Reset values: out_valid=0, sum=0, co=0, ovf=0, zero=0, neg=0; every stage valid bit=0.
//  - Stage k (0..LAT-1) computes bits [4*GPS*k +: 4*GPS] from registered carry c_k
//    (c_0 = op_sub ? 1 : cin; B input pre-inverted when op_sub). Result slices already
//    produced and unprocessed operand slices travel with the token (skewed pipeline).
//  - Per-stage registers: valid, carry, partial sum, remaining A/B slices; last stage
//    registers drive sum/co/ovf/zero/neg directly (flags computed combinationally from
//    the final slice before the output register).
//  - Latency: input accepted at edge T -> out_valid=1 after edge T+LAT-1 (LAT cycles from
//    the in_valid&&in_ready cycle to the cycle result is visible), absent stalls.
//  - Throughput: one op/cycle when out_ready stays high.
//  - Handshake: stall = out_valid && !out_ready; in_ready = !stall (combinational).
//    On stall every stage holds (global enable); outputs stable until accepted.
//    Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Bubbles are not compacted: an empty stage advances like a full one when not stalled.
//  - in_valid=0 while in_ready=1 -> bubble (valid=0) enters stage 0; data ignored.
//  - Simultaneous accept-in and accept-out in the same cycle is legal and loses nothing.
//  - a/b/op_sub/cin sampled only on input transfer; changes while stalled are ignored.
//  - Wrap-around: sum is modulo 2^WIDTH; co reports the dropped bit.
//  - Reset mid-operation: all in-flight tokens discarded, out_valid drops immediately
//    (asynchronously); no partial result is ever presented.
//  - Group logic per 4 bits: g=a&b, p=a|b; c1..c3 and group co by full lookahead
//    equations, not ripple; group-to-group carry inside a stage ripples over GPS groups.
// TESTING (WIDTH=32, GPS=2, LAT=4)
//  1 Assert reset with pipe full -> out_valid=0, sum=0, flags 0, in_ready=1 at once.
//  2 a=FFFFFFFF b=00000001 add cin=0 -> 4 cycles later sum=00000000 co=1 zero=1 ovf=0 neg=0.
//  3 a=80000000 b=00000001 sub -> sum=7FFFFFFF co=1 ovf=1 neg=0; a=0 b=1 sub -> FFFFFFFF co=0 neg=1.
//  4 8 back-to-back adds (i, 3*i, cin=i[0]), out_ready=1 -> 8 results in order on 8 consecutive cycles.
//  5 Pipe full, out_ready=0 for 3 cycles -> in_ready=0, sum held stable, no drop or duplicate on release.
//  6 a=7FFFFFFF b=00000000 cin=1 add -> sum=80000000 ovf=1 neg=1 co=0 (carry crosses all stages).

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready streaming and NZCV-style flags.
// Each stage resolves GPS 4-bit lookahead groups; the unprocessed operand slices and the
// result slices already produced travel down the pipe with the token.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GPS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NGRP = WIDTH / 4;
  localparam int unsigned SW   = 4 * GPS;
  localparam int unsigned LAT  = NGRP / GPS;

  // 4-bit lookahead group: returns {group carry out, 4-bit sum}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = x & y;
    p  = x | y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, x ^ y ^ {c3, c2, c1, ci}};
  endfunction

  // Global stall: a presented result that is not taken freezes every stage
  logic stall_c;
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  for (genvar k = 0; k < int'(LAT); k++) begin : g_stg
    localparam int unsigned IW = WIDTH - SW * k;  // operand bits still to be processed
    localparam int unsigned OW = SW * (k + 1);    // result bits produced up to this stage

    logic            v_i;
    logic            c_i;
    logic [IW-1:0]   ar_i;
    logic [IW-1:0]   br_i;
    logic [SW-1:0]   ss;
    logic [GPS:0]    gc;
    logic [OW-1:0]   s_d;
    logic            v_q;
    logic            c_q;
    logic [OW-1:0]   s_q;

    if (k == 0) begin : g_head
      // Subtraction folds into add: invert B and force carry-in
      assign v_i  = in_valid;
      assign c_i  = op_sub ? 1'b1 : cin;
      assign ar_i = a;
      assign br_i = op_sub ? ~b : b;
      assign s_d  = ss;
    end else begin : g_body
      assign v_i  = g_stg[k-1].v_q;
      assign c_i  = g_stg[k-1].c_q;
      assign ar_i = g_stg[k-1].g_fwd.a_q;
      assign br_i = g_stg[k-1].g_fwd.b_q;
      assign s_d  = {ss, g_stg[k-1].s_q};
    end

    // Slice add: lookahead inside each group, carry ripples group to group
    always_comb begin
      logic [4:0] r;
      r     = '0;
      gc    = '0;
      ss    = '0;
      gc[0] = c_i;
      for (int j = 0; j < int'(GPS); j++) begin
        r            = cla4(ar_i[4*j +: 4], br_i[4*j +: 4], gc[j]);
        ss[4*j +: 4] = r[3:0];
        gc[j+1]      = r[4];
      end
    end

    // Token, carry and partial-sum registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall_c) begin
        v_q <= v_i;
        c_q <= gc[GPS];
        s_q <= s_d;
      end
    end

    if (k < int'(LAT) - 1) begin : g_fwd
      localparam int unsigned RW = IW - SW;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      // Carry the not-yet-added operand slices forward with the token
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall_c) begin
          a_q <= ar_i[IW-1:SW];
          b_q <= br_i[IW-1:SW];
        end
      end
    end else begin : g_tail
      logic msb_cin;
      logic ovf_q;
      logic zero_q;
      logic neg_q;

      // Carry into the MSB recovered from the MSB sum bit and its operands
      assign msb_cin = ss[SW-1] ^ ar_i[SW-1] ^ br_i[SW-1];

      // Flags captured alongside the final slice
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (!stall_c) begin
          ovf_q  <= gc[GPS] ^ msb_cin;
          zero_q <= (s_d == '0);
          neg_q  <= ss[SW-1];
        end
      end
    end
  end

  assign out_valid = g_stg[LAT-1].v_q;
  assign sum       = g_stg[LAT-1].s_q;
  assign co        = g_stg[LAT-1].c_q;
  assign ovf       = g_stg[LAT-1].g_tail.ovf_q;
  assign zero      = g_stg[LAT-1].g_tail.zero_q;
  assign neg       = g_stg[LAT-1].g_tail.neg_q;

endmodule
